// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/192/256 block encryptor: in-core key expansion (one word per clock)
// followed by one cipher round per clock. Optional AES_KEY_CACHE_EN reuses the last schedule.
module aes_encrypt_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] plaintext,
  input  logic [255:0] key,
  input  logic [2:0]   key_len,
  output logic [127:0] ciphertext,
  output logic         ready
);

  // Handshake: key_len != 0 seen in IDLE is a request (inputs latched on that edge);
  // ready is asserted in DONE and held until key_len returns to 0.
  typedef enum logic [2:0] {IDLE, KEYX, INIT, ROUND, DONE} state_t;

  state_t       state_q, state_d;
  logic [127:0] pt_q;
  logic [127:0] st;
  logic [1:0]   mode_q;
  logic [5:0]   widx;
  logic [2:0]   kmod;
  logic [7:0]   rcon;
  logic [3:0]   rnd;
  logic [31:0]  w [0:59];

  logic [1:0]   req_mode;
  logic [255:0] req_al;
  logic [5:0]   req_nk;
  logic [3:0]   nk, nr;
  logic [5:0]   wlast;
  logic [31:0]  prev_w, back_w, temp_w, new_w;
  logic [5:0]   rbase;
  logic [127:0] rk_cur, round_out;
  logic         hit;

`ifdef AES_KEY_CACHE_EN
  logic [255:0] key_q;
  logic         cache_valid;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as a^254 (multiplicative inverse, 0 -> 0) followed by the 0x63 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, a);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  // SubBytes, ShiftRows and (unless last) MixColumns; byte n sits at row n%4, column n/4.
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic last);
    logic [7:0]   b [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int n = 0; n < 16; n++) b[n] = sbox(s[127-8*n -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last) begin
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return o;
  endfunction

  always_comb begin
    req_mode = 2'd0;
    req_al   = {key[127:0], 128'h0};
    req_nk   = 6'd4;
    if (key_len[2]) begin
      req_mode = 2'd2;
      req_al   = key;
      req_nk   = 6'd8;
    end else if (key_len[1]) begin
      req_mode = 2'd1;
      req_al   = {key[191:0], 64'h0};
      req_nk   = 6'd6;
    end

    case (mode_q)
      2'd1:    begin nk = 4'd6; nr = 4'd12; wlast = 6'd51; end
      2'd2:    begin nk = 4'd8; nr = 4'd14; wlast = 6'd59; end
      default: begin nk = 4'd4; nr = 4'd10; wlast = 6'd43; end
    endcase

    prev_w = w[widx - 6'd1];
    back_w = w[widx - {2'b00, nk}];
    if (kmod == 3'd0)
      temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon, 24'h0};
    else if (mode_q == 2'd2 && kmod == 3'd4)
      temp_w = sub_word(prev_w);
    else
      temp_w = prev_w;
    new_w = temp_w ^ back_w;

    // rnd is 0 in INIT, so the same fetch supplies round key 0 there.
    rbase     = {rnd, 2'b00};
    rk_cur    = {w[rbase], w[rbase + 6'd1], w[rbase + 6'd2], w[rbase + 6'd3]};
    round_out = enc_round(st, rnd == nr) ^ rk_cur;

`ifdef AES_KEY_CACHE_EN
    hit = cache_valid && (req_al == key_q) && (req_mode == mode_q);
`else
    hit = 1'b0;
`endif

    state_d = state_q;
    case (state_q)
      IDLE:    if (key_len != 3'd0) state_d = hit ? INIT : KEYX;
      KEYX:    if (widx == wlast) state_d = INIT;
      INIT:    state_d = ROUND;
      ROUND:   if (rnd == nr) state_d = DONE;
      DONE:    if (key_len == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ciphertext <= '0;
      rnd        <= '0;
      widx       <= '0;
      kmod       <= '0;
      rcon       <= 8'h01;
`ifdef AES_KEY_CACHE_EN
      cache_valid <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (key_len != 3'd0) begin
            pt_q   <= plaintext;
            mode_q <= req_mode;
            if (!hit) begin
              w[0] <= req_al[255:224];
              w[1] <= req_al[223:192];
              w[2] <= req_al[191:160];
              w[3] <= req_al[159:128];
              w[4] <= req_al[127:96];
              w[5] <= req_al[95:64];
              w[6] <= req_al[63:32];
              w[7] <= req_al[31:0];
              widx <= req_nk;
              kmod <= 3'd0;
              rcon <= 8'h01;
`ifdef AES_KEY_CACHE_EN
              key_q       <= req_al;
              cache_valid <= 1'b0;
`endif
            end
          end
        end
        KEYX: begin
          w[widx] <= new_w;
          widx    <= widx + 6'd1;
          kmod    <= ({1'b0, kmod} == nk - 4'd1) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0) rcon <= xtime(rcon);
`ifdef AES_KEY_CACHE_EN
          if (widx == wlast) cache_valid <= 1'b1;
`endif
        end
        INIT: begin
          st  <= pt_q ^ rk_cur;
          rnd <= 4'd1;
        end
        ROUND: begin
          st <= round_out;
          if (rnd == nr) begin
            ciphertext <= round_out;
            rnd        <= 4'd0;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed-vector bench for aes_encrypt_core: FIPS-197 known answers, latency,
// mode priority, input latching, hold/release, mid-run reset and (AES_KEY_CACHE_EN) cache hits.
module tb_aes_encrypt_core;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] plaintext;
  logic [255:0] key;
  logic [2:0]   key_len;
  logic [127:0] ciphertext;
  logic         ready;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] PT1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128A = {128'hdeadbeefcafef00d0123456789abcdef,
                                    128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [127:0] CT128A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K128B = {128'hffffffffffffffffffffffffffffffff,
                                    128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [127:0] PT2    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT128B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K192  = {64'h55aa55aa55aa55aa,
                                    192'h000102030405060708090a0b0c0d0e0f1011121314151617};
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

`ifdef AES_KEY_CACHE_EN
  logic [255:0] c_key;
  logic [2:0]   c_sel;
  bit           c_valid = 1'b0;
`endif

  aes_encrypt_core dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .plaintext  (plaintext),
    .key        (key),
    .key_len    (key_len),
    .ciphertext (ciphertext),
    .ready      (ready)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, measure edges from the accept edge to ready, check the result,
  // then either hold key_len (ready must stay, no restart) or release it early.
  task automatic run_vec(input string tag, input logic [2:0] kl, input logic [255:0] k,
                         input logic [127:0] pt, input logic [127:0] ct,
                         input int lat_full, input int lat_cached, input bit drop_early);
    int           lat;
    int           lat_exp;
    bit           hit;
    logic [127:0] exp;
    hit = 1'b0;
`ifdef AES_KEY_CACHE_EN
    begin
      logic [255:0] used;
      logic [2:0]   sel;
      sel  = kl[2] ? 3'd4 : (kl[1] ? 3'd2 : 3'd1);
      used = kl[2] ? k : (kl[1] ? {64'h0, k[191:0]} : {128'h0, k[127:0]});
      hit  = c_valid && (c_sel == sel) && (c_key == used);
      c_valid = 1'b1;
      c_sel   = sel;
      c_key   = used;
    end
`endif
    lat_exp = hit ? lat_cached : lat_full;
    @(negedge clk);
    key_len   = kl;
    key       = k;
    plaintext = pt;
    exp_q.push_back(ct);
    @(posedge clk);
    #1;
    if (drop_early) begin
      key_len   = 3'd0;
      plaintext = ~pt;
      key       = ~k;
    end
    lat = 0;
    while (!ready && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " ready"}, {127'h0, ready}, 128'h1);
    check({tag, " latency"}, lat, lat_exp);
    exp = exp_q.pop_front();
    check({tag, " ct"}, ciphertext, exp);
    if (!drop_early) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1;
        check({tag, " hold ready"}, {127'h0, ready}, 128'h1);
      end
      check({tag, " hold ct"}, ciphertext, exp);
      @(negedge clk);
      key_len = 3'd0;
    end
    @(posedge clk);
    #1;
    check({tag, " idle ready"}, {127'h0, ready}, 128'h0);
    check({tag, " idle ct"}, ciphertext, exp);
  endtask

  initial begin
    reset_n   = 1'b0;
    key_len   = 3'd0;
    key       = '0;
    plaintext = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {127'h0, ready}, 128'h0);
    check("reset ct", ciphertext, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;

    run_vec("aes128_a",    3'b001, K128A, PT1, CT128A, 51, 11, 1'b0);
    run_vec("aes128_b",    3'b001, K128B, PT2, CT128B, 51, 11, 1'b1);
    run_vec("aes192",      3'b010, K192,  PT1, CT192,  59, 13, 1'b0);
    run_vec("aes192_prio", 3'b011, K192,  PT1, CT192,  59, 13, 1'b1);
    run_vec("aes256",      3'b100, K256,  PT1, CT256,  67, 15, 1'b0);
    run_vec("aes256_prio", 3'b111, K256,  PT1, CT256,  67, 15, 1'b0);

    // abort an AES-128 run with a reset pulse at edge 20 after acceptance
    @(negedge clk);
    key_len   = 3'b001;
    key       = K128A;
    plaintext = PT1;
    @(posedge clk);
    #1;
    key_len = 3'd0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrun ready", {127'h0, ready}, 128'h0);
    check("midrun ct", ciphertext, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
`ifdef AES_KEY_CACHE_EN
    c_valid = 1'b0;
`endif
    repeat (60) @(posedge clk);
    #1;
    check("aborted ready", {127'h0, ready}, 128'h0);
    check("aborted ct", ciphertext, 128'h0);

    run_vec("aes128_after_reset", 3'b001, K128A, PT1, CT128A, 51, 11, 1'b0);
    run_vec("aes128_repeat",      3'b001, K128A, PT1, CT128A, 51, 11, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
